bram_result_streamer: RTL
=========================

Name: bram_result_streamer

Overview:
- Drains softmax result rows from the shared result BRAM after the softmax FSM completes.
- Each run reads NUM_ROWS consecutive rows starting at BASE_ADDR.
- Each ROW_W-bit row is serialized into BEAT_W-bit beats on a valid/ready output stream toward the host/DMA side.
- Double-buffers rows, so the stream runs without bubbles at row boundaries while ready is held high.

Parameters:
ROW_W, 1024, BRAM row width in bits
BEAT_W, 32, output beat width; ROW_W must be an integer multiple of BEAT_W
NUM_ROWS, 12, rows drained per run
BASE_ADDR, 12, BRAM address of the first result row
ADDR_W, 5, BRAM address width
BRAM_LAT, 1, cycles from en/addr sampled by BRAM to i_bram_rdata valid (1..3)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset: synchronous, active-high
i_start  in  1  run request, rising-edge detected
o_busy  out  1  high from accepted start until o_done
o_done  out  1  one-cycle pulse after the final beat is accepted
o_bram_en  out  1  BRAM read enable, one cycle per row read
o_bram_addr  out  ADDR_W  BRAM read address
i_bram_rdata  in  ROW_W  BRAM read data
o_m_valid  out  1  output beat valid
o_m_data  out  BEAT_W  output beat
o_m_row_end  out  1  qualifies the final beat of each row
o_m_last  out  1  qualifies the final beat of the final row
i_m_ready  in  1  downstream ready

Behaviour:
- Reset: all outputs 0, state IDLE, both buffers empty, counters 0, edge detector primed with i_start=1 so a start held through reset is not accepted.
- Reset mid-run aborts immediately; in-flight BRAM data is discarded; o_done is not pulsed.
- Start acceptance:
  - A start is accepted only in IDLE, on a 0->1 transition of i_start.
  - Edges seen while busy are ignored and not queued.
- States:
  - IDLE -> FILL: on an accepted start.
  - FILL -> STREAM: when the row 0 read is captured into the active buffer.
  - STREAM -> DONE: when the final beat of row NUM_ROWS-1 is accepted.
  - DONE -> IDLE: after one cycle. o_done=1 in DONE.
- Timing, with start sampled in cycle 0:
  - Cycle 1: o_bram_en=1, o_bram_addr=BASE_ADDR. All BRAM outputs are registered.
  - Cycle 1+BRAM_LAT: rdata is captured.
  - Cycle 2+BRAM_LAT: o_m_valid first goes high.
- Read issue and prefetch:
  - Every read is issued exactly once, with o_bram_en high for exactly one cycle; o_bram_en=0 at all other times.
  - Row r is read at address BASE_ADDR+r, r=0..NUM_ROWS-1, with no wrap.
  - The shadow-buffer read for row r+1 is issued when the active buffer holds row r, the shadow buffer is empty, and r+1<NUM_ROWS.
  - At most one read is outstanding at a time.
- Beat order and flags:
  - Beat b of a row is row[b*BEAT_W +: BEAT_W], b=0..ROW_W/BEAT_W-1, LSB first.
  - o_m_row_end=1 on b=last.
  - o_m_last=1 on b=last of row NUM_ROWS-1 only.
- Handshake:
  - A beat transfers when o_m_valid && i_m_ready.
  - While o_m_valid=1 && i_m_ready=0, o_m_data, o_m_row_end and o_m_last hold stable.
  - o_m_valid never drops without a transfer.
- Row boundary:
  - When the last beat of a row transfers and the shadow buffer is full, the shadow becomes active in the same edge; the next beat is valid the next cycle, with no bubble.
  - If the shadow buffer is not yet full, o_m_valid=0 until the capture.
  - With BRAM_LAT<=3 and 32 beats per row, this never happens under continuous ready.
- Counters:
  - beat counter is $clog2(ROW_W/BEAT_W) bits.
  - row counters are $clog2(NUM_ROWS+1) bits.
  - Address = BASE_ADDR + row, truncated to ADDR_W. The integrator guarantees BASE_ADDR+NUM_ROWS <= 2^ADDR_W.
- Simultaneity: a capture into the shadow buffer and a transfer from the active buffer in the same cycle must both take effect.

Test Plan:
- Defaults, ready held 1, row r filled with 32-bit words {r[7:0],b[7:0],16'hA5A5}, start pulse at cycle 0:
  - Reads at addr 12..23, one each.
  - First valid at cycle 3.
  - 384 consecutive beats, in cycles 3..386, matching row/beat order.
  - o_m_row_end on beats 31, 63, …; o_m_last only on beat 383.
  - o_done at cycle 387; o_busy falls with it.
- Random i_m_ready at 30% duty:
  - Identical beat sequence.
  - Data and flags stable during every stall.
  - Exactly 12 BRAM reads.
- Ready low for 50 cycles starting at the row_end beat of row 4:
  - Beat holds.
  - No extra read beyond row 5's prefetch.
  - Row 5 beat 0 follows the transfer with no bubble.
- i_start held high for 1000 cycles:
  - Exactly one run.
  - Second start pulses during busy are ignored.
  - A new pulse after o_done starts a second identical run.
- i_rst asserted at beat 100 for 1 cycle:
  - All outputs 0 the next cycle; no o_done.
  - A subsequent start produces a full, correct 384-beat run from row 0.
- BRAM_LAT=3, ready held 1:
  - First valid at cycle 5.
  - Still zero bubbles across all row boundaries.

Source files
------------

// File: rtl/bram_result_streamer.sv
// rtl/bram_result_streamer.sv - drains softmax result rows from BRAM as a double-buffered beat stream
module bram_result_streamer #(
    parameter int ROW_W     = 1024,
    parameter int BEAT_W    = 32,
    parameter int NUM_ROWS  = 12,
    parameter int BASE_ADDR = 12,
    parameter int ADDR_W    = 5,
    parameter int BRAM_LAT  = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_bram_en,
    output logic [ADDR_W-1:0] o_bram_addr,
    input  logic [ROW_W-1:0]  i_bram_rdata,
    output logic              o_m_valid,
    output logic [BEAT_W-1:0] o_m_data,
    output logic              o_m_row_end,
    output logic              o_m_last,
    input  logic              i_m_ready
);

    localparam int BEATS = ROW_W / BEAT_W;
    localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int RC_W  = $clog2(NUM_ROWS + 1);

    localparam logic [BC_W-1:0]   LAST_BEAT = BC_W'(BEATS - 1);
    localparam logic [RC_W-1:0]   LAST_ROW  = RC_W'(NUM_ROWS - 1);
    localparam logic [RC_W-1:0]   ROWS      = RC_W'(NUM_ROWS);
    localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                         start_q;
    logic                         start_acc;
    logic [BRAM_LAT-1:0]          rd_pipe;
    logic                         capture;
    logic                         outstanding;
    logic                         issue;
    logic [BEATS-1:0][BEAT_W-1:0] act_buf;
    logic [BEATS-1:0][BEAT_W-1:0] sh_buf;
    logic                         act_full;
    logic                         sh_full;
    logic [BC_W-1:0]              beat_cnt;
    logic [RC_W-1:0]              rd_row;
    logic [RC_W-1:0]              out_row;
    logic                         bram_en_q;
    logic [ADDR_W-1:0]            bram_addr_q;
    logic                         m_valid;
    logic                         row_end;
    logic                         xfer;

    // Edge-detected start, honoured only while idle so edges during a run are dropped.
    assign start_acc   = (state == IDLE) && i_start && !start_q;
    // Read data is valid BRAM_LAT cycles after the registered enable is seen by the BRAM.
    assign capture     = rd_pipe[BRAM_LAT-1];
    assign outstanding = bram_en_q || (|rd_pipe);
    assign m_valid     = (state == STREAM) && act_full;
    assign row_end     = (beat_cnt == LAST_BEAT);
    assign xfer        = m_valid && i_m_ready;
    // First read on start; afterwards prefetch the next row into the empty shadow buffer.
    assign issue       = start_acc ||
                         ((state == STREAM) && act_full && !sh_full && !outstanding && (rd_row < ROWS));

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_acc) state_nxt = FILL;
            FILL:    if (capture) state_nxt = STREAM;
            STREAM:  if (xfer && row_end && (out_row == LAST_ROW)) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic; beat fields are forced low whenever no beat is offered.
    always_comb begin
        o_busy      = (state == FILL) || (state == STREAM);
        o_done      = (state == DONE);
        o_bram_en   = bram_en_q;
        o_bram_addr = bram_addr_q;
        o_m_valid   = m_valid;
        o_m_data    = m_valid ? act_buf[beat_cnt] : '0;
        o_m_row_end = m_valid && row_end;
        o_m_last    = m_valid && row_end && (out_row == LAST_ROW);
    end

    // Read issue, read-latency tracking, double buffer and beat/row counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            start_q     <= 1'b1;
            rd_pipe     <= '0;
            bram_en_q   <= 1'b0;
            bram_addr_q <= '0;
            rd_row      <= '0;
            out_row     <= '0;
            beat_cnt    <= '0;
            act_full    <= 1'b0;
            sh_full     <= 1'b0;
        end else begin
            start_q   <= i_start;
            rd_pipe   <= (rd_pipe << 1) | BRAM_LAT'(bram_en_q);
            bram_en_q <= issue;
            if (issue) begin
                bram_addr_q <= BASE_A + ADDR_W'(rd_row);
                rd_row      <= rd_row + 1'b1;
            end

            if (xfer) begin
                beat_cnt <= row_end ? '0 : beat_cnt + 1'b1;
                if (row_end) begin
                    out_row <= out_row + 1'b1;
                    if (sh_full) begin
                        act_buf <= sh_buf;
                        sh_full <= 1'b0;
                    end else begin
                        act_full <= 1'b0;
                    end
                end
            end

            // A row landing while the active row drains its last beat goes straight to active.
            if (capture) begin
                if (!act_full || (xfer && row_end && !sh_full)) begin
                    act_buf  <= i_bram_rdata;
                    act_full <= 1'b1;
                end else begin
                    sh_buf  <= i_bram_rdata;
                    sh_full <= 1'b1;
                end
            end

            if (state == DONE) begin
                rd_row   <= '0;
                out_row  <= '0;
                beat_cnt <= '0;
                act_full <= 1'b0;
                sh_full  <= 1'b0;
            end
        end
    end

endmodule
